// File: rtl/pipe_cpu.sv
// pipe_cpu: five-stage MIPS-subset pipeline (IF, ID, EX, MEM, WB) with its own
// byte-wide instruction/data memories, 32x32 register file and HI/LO pair.
// Build macro PIPE_CPU_FORWARDING_EN adds EX operand forwarding and a one-cycle
// load-use stall; without it software must space dependent instructions.

// Byte-addressed little-endian word memory; addresses wrap modulo BYTES.
module pipe_cpu_mem #(
  parameter int BYTES = 128
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o
);
  localparam int          AW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [31:0] SIZE = 32'(BYTES);

  logic [7:0] mem_array [BYTES];

  function automatic logic [AW-1:0] idx(input logic [31:0] a, input logic [31:0] k);
    return AW'((a + k) % SIZE);
  endfunction

  assign rdata_o = {mem_array[idx(raddr_i, 32'd3)], mem_array[idx(raddr_i, 32'd2)],
                    mem_array[idx(raddr_i, 32'd1)], mem_array[idx(raddr_i, 32'd0)]};

  // Word store, one byte lane per address
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) mem_array[idx(waddr_i, 32'(k))] <= wdata_i[8*k +: 8];
    end
  end
endmodule

// Two read ports, one write port; $0 is hardwired zero, reads see same-cycle write.
module pipe_cpu_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] file_array [32];

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra1_i) ? wd_i : file_array[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra2_i) ? wd_i : file_array[ra2_i];

  // Writeback port; writes to $0 are dropped
  always_ff @(posedge clk) begin
    if (we_i && wa_i != 5'd0) file_array[wa_i] <= wd_i;
  end
endmodule

module pipe_cpu #(
  parameter int IMEM_BYTES = 128,
  parameter int DMEM_BYTES = 128
) (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_BNE = 6'd5;
  localparam logic [5:0] OP_ADDIU = 6'd9, OP_LW = 6'd35, OP_SW = 6'd43;
  localparam logic [5:0] FN_SLL = 6'd0, FN_MFHI = 6'd16, FN_MFLO = 6'd18, FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD = 6'd32, FN_SUB = 6'd34, FN_AND = 6'd36, FN_OR = 6'd37, FN_SLT = 6'd42;

  // IF
  logic [31:0] pc, pc_d, instr_IF;
  logic [5:0]  opcode_IF, funct_IF;
  // IF/ID
  logic [31:0] id_instr_q, id_pc_q;
  // ID/EX (imm field also carries rd/shamt/funct for R-type)
  logic [5:0]  ex_op_q;
  logic [4:0]  ex_rt_q;
  logic [15:0] ex_imm_q;
  logic [31:0] ex_pc_q, ex_a_q, ex_b_q;
  // EX/MEM
  logic [31:0] mem_res_q, mem_b_q;
  logic [4:0]  mem_wa_q;
  logic        mem_wen_q, mem_ld_q, mem_st_q;
  // MEM/WB
  logic [31:0] wb_data_q;
  logic [4:0]  wb_wa_q;
  logic        wb_wen_q;
  logic [31:0] hi_q, lo_q;

  pipe_cpu_mem #(.BYTES(IMEM_BYTES)) InstrMem (
    .clk(clk), .we_i(1'b0), .waddr_i(32'd0), .wdata_i(32'd0), .raddr_i(pc), .rdata_o(instr_IF));

  assign opcode_IF = instr_IF[31:26];
  assign funct_IF  = instr_IF[5:0];

  // ID: register read and J resolution
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_a, id_b, j_target;
  logic        id_jump;

  assign id_op    = id_instr_q[31:26];
  assign id_rs    = id_instr_q[25:21];
  assign id_rt    = id_instr_q[20:16];
  assign id_jump  = (id_op == OP_J);
  assign j_target = ((id_pc_q + 32'd4) & 32'hF000_0000) | {4'd0, id_instr_q[25:0], 2'b00};

  pipe_cpu_regfile RegFile (
    .clk(clk), .we_i(wb_wen_q), .wa_i(wb_wa_q), .wd_i(wb_data_q),
    .ra1_i(id_rs), .ra2_i(id_rt), .rd1_o(id_a), .rd2_o(id_b));

  // EX
  logic [4:0]  ex_rd, ex_shamt, ex_wa;
  logic [5:0]  ex_fn;
  logic [31:0] ex_sext, op_a, op_b, ex_res, br_target;
  logic [63:0] ex_prod;
  logic        ex_wen, ex_ld, ex_st, ex_mul, br_taken, stall;

`ifdef PIPE_CPU_FORWARDING_EN
  logic [4:0] ex_rs_q;

  // rs travels to EX only for forwarding compares
  always_ff @(posedge clk) begin
    if (rst || br_taken || stall) ex_rs_q <= 5'd0;
    else                          ex_rs_q <= id_rs;
  end

  // Operand select: EX/MEM ALU result beats MEM/WB; $0 is never forwarded
  always_comb begin
    op_a = ex_a_q;
    op_b = ex_b_q;
    if (wb_wen_q && wb_wa_q != 5'd0 && wb_wa_q == ex_rs_q) op_a = wb_data_q;
    if (wb_wen_q && wb_wa_q != 5'd0 && wb_wa_q == ex_rt_q) op_b = wb_data_q;
    if (mem_wen_q && !mem_ld_q && mem_wa_q != 5'd0 && mem_wa_q == ex_rs_q) op_a = mem_res_q;
    if (mem_wen_q && !mem_ld_q && mem_wa_q != 5'd0 && mem_wa_q == ex_rt_q) op_b = mem_res_q;
  end

  assign stall = (ex_op_q == OP_LW) && (ex_rt_q != 5'd0) &&
                 ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
`else
  assign op_a  = ex_a_q;
  assign op_b  = ex_b_q;
  assign stall = 1'b0;
`endif

  assign ex_rd     = ex_imm_q[15:11];
  assign ex_shamt  = ex_imm_q[10:6];
  assign ex_fn     = ex_imm_q[5:0];
  assign ex_sext   = {{16{ex_imm_q[15]}}, ex_imm_q};
  assign ex_prod   = {32'd0, op_a} * {32'd0, op_b};
  assign br_target = ex_pc_q + 32'd4 + {ex_sext[29:0], 2'b00};

  // Execute decode; anything unrecognised leaves every write enable low
  always_comb begin
    ex_res   = 32'd0;
    ex_wa    = ex_rd;
    ex_wen   = 1'b0;
    ex_ld    = 1'b0;
    ex_st    = 1'b0;
    ex_mul   = 1'b0;
    br_taken = 1'b0;
    case (ex_op_q)
      OP_R: begin
        ex_wen = 1'b1;
        case (ex_fn)
          FN_ADD:   ex_res = op_a + op_b;
          FN_SUB:   ex_res = op_a - op_b;
          FN_AND:   ex_res = op_a & op_b;
          FN_OR:    ex_res = op_a | op_b;
          FN_SLT:   ex_res = {31'd0, $signed(op_a) < $signed(op_b)};
          FN_SLL:   ex_res = op_b << ex_shamt;
          FN_MFHI:  ex_res = hi_q;
          FN_MFLO:  ex_res = lo_q;
          FN_MULTU: begin ex_mul = 1'b1; ex_wen = 1'b0; end
          default:  ex_wen = 1'b0;
        endcase
      end
      OP_ADDIU: begin ex_res = op_a + ex_sext; ex_wa = ex_rt_q; ex_wen = 1'b1; end
      OP_LW:    begin ex_res = op_a + ex_sext; ex_wa = ex_rt_q; ex_wen = 1'b1; ex_ld = 1'b1; end
      OP_SW:    begin ex_res = op_a + ex_sext; ex_st = 1'b1; end
      OP_BEQ:   br_taken = (op_a == op_b);
      OP_BNE:   br_taken = (op_a != op_b);
      default:  ;
    endcase
  end

  // MEM: data memory, store gated by reset so no partial write escapes
  logic [31:0] dmem_rdata;

  pipe_cpu_mem #(.BYTES(DMEM_BYTES)) DatMem (
    .clk(clk), .we_i(mem_st_q & ~rst), .waddr_i(mem_res_q), .wdata_i(mem_b_q),
    .raddr_i(mem_res_q), .rdata_o(dmem_rdata));

  // Next PC: taken branch beats J, J beats a load-use hold
  always_comb begin
    pc_d = pc + 32'd4;
    if (br_taken)     pc_d = br_target;
    else if (id_jump) pc_d = j_target;
    else if (stall)   pc_d = pc;
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (rst) pc <= 32'd0;
    else     pc <= pc_d;
  end

  // IF/ID: flushed by any redirect, held during a load-use stall
  always_ff @(posedge clk) begin
    if (rst || br_taken || id_jump) begin
      id_instr_q <= 32'd0;
      id_pc_q    <= 32'd0;
    end else if (!stall) begin
      id_instr_q <= {opcode_IF, instr_IF[25:6], funct_IF};
      id_pc_q    <= pc;
    end
  end

  // ID/EX: bubble on taken branch or load-use stall
  always_ff @(posedge clk) begin
    if (rst || br_taken || stall) begin
      ex_op_q <= 6'd0; ex_rt_q <= 5'd0; ex_imm_q <= 16'd0;
      ex_pc_q <= 32'd0; ex_a_q <= 32'd0; ex_b_q <= 32'd0;
    end else begin
      ex_op_q <= id_op; ex_rt_q <= id_rt; ex_imm_q <= id_instr_q[15:0];
      ex_pc_q <= id_pc_q; ex_a_q <= id_a; ex_b_q <= id_b;
    end
  end

  // HI/LO take the product at the end of MULTU's EX cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (ex_mul) begin
      hi_q <= ex_prod[63:32];
      lo_q <= ex_prod[31:0];
    end
  end

  // EX/MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_res_q <= 32'd0; mem_b_q <= 32'd0; mem_wa_q <= 5'd0;
      mem_wen_q <= 1'b0;  mem_ld_q <= 1'b0; mem_st_q <= 1'b0;
    end else begin
      mem_res_q <= ex_res; mem_b_q <= op_b; mem_wa_q <= ex_wa;
      mem_wen_q <= ex_wen; mem_ld_q <= ex_ld; mem_st_q <= ex_st;
    end
  end

  // MEM/WB: select load data or ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_q <= 32'd0; wb_wa_q <= 5'd0; wb_wen_q <= 1'b0;
    end else begin
      wb_data_q <= mem_ld_q ? dmem_rdata : mem_res_q;
      wb_wa_q   <= mem_wa_q;
      wb_wen_q  <= mem_wen_q;
    end
  end
endmodule

// File: tb/tb_pipe_cpu.sv
// Directed bench for pipe_cpu: programs are poked into InstrMem while reset is
// held, then run for a fixed number of cycles and architectural state checked.
module tb_pipe_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  pipe_cpu #(.IMEM_BYTES(128), .DMEM_BYTES(128)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int addr);
    return {6'd2, 26'(addr >> 2)};
  endfunction

  task automatic hold_reset;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 128; i++) dut.InstrMem.mem_array[i] = 8'h00;
  endtask

  task automatic release_reset;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic put_instr(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.InstrMem.mem_array[addr + k] = w[8*k +: 8];
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] exp_pc;
    hold_reset();
    dut.RegFile.file_array[1] = 32'hCAFE_0001;
    dut.DatMem.mem_array[0]   = 8'h5A;
    release_reset();
    chk_cnt++; if (dut.pc !== 32'd0) $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'd0); else pass_cnt++;
    chk_cnt++; if (dut.instr_IF !== 32'd0) $display("FAIL reset_instr: got %h expected %h", dut.instr_IF, 32'd0); else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      run(1);
      exp_pc = 32'(4 * k);
      chk_cnt++; if (dut.pc !== exp_pc) $display("FAIL seq_pc%0d: got %h expected %h", k, dut.pc, exp_pc); else pass_cnt++;
    end
    run(6);
    chk_cnt++; if (dut.RegFile.file_array[1] !== 32'hCAFE_0001) $display("FAIL nop_reg1: got %h expected %h", dut.RegFile.file_array[1], 32'hCAFE_0001); else pass_cnt++;
    chk_cnt++; if (dut.DatMem.mem_array[0] !== 8'h5A) $display("FAIL nop_dmem0: got %h expected %h", dut.DatMem.mem_array[0], 8'h5A); else pass_cnt++;
    chk_cnt++; if (dut.hi_q !== 32'd0) $display("FAIL reset_hi: got %h expected %h", dut.hi_q, 32'd0); else pass_cnt++;
    chk_cnt++; if (dut.lo_q !== 32'd0) $display("FAIL reset_lo: got %h expected %h", dut.lo_q, 32'd0); else pass_cnt++;
  endtask

  task automatic test_alu;
    hold_reset();
    dut.RegFile.file_array[1]  = 32'd5;
    dut.RegFile.file_array[2]  = 32'd3;
    dut.RegFile.file_array[12] = 32'hFFFF_FFFF;
    put_instr(0,   r_op(1, 2, 3, 0, 32));   // ADD $3,$1,$2
    put_instr(16,  r_op(1, 2, 4, 0, 34));   // SUB $4,$1,$2
    put_instr(32,  r_op(2, 1, 5, 0, 42));   // SLT $5,$2,$1
    put_instr(48,  r_op(0, 1, 6, 2, 0));    // SLL $6,$1,2
    put_instr(64,  r_op(12, 1, 13, 0, 42)); // SLT $13,$12,$1 (signed)
    put_instr(80,  r_op(1, 2, 14, 0, 36));  // AND $14,$1,$2
    put_instr(96,  r_op(1, 2, 15, 0, 37));  // OR  $15,$1,$2
    put_instr(112, r_op(12, 1, 16, 0, 32)); // ADD $16,$12,$1 (wraps)
    release_reset();
    run(34);
    chk_cnt++; if (dut.RegFile.file_array[3]  !== 32'd8) $display("FAIL add: got %h expected %h", dut.RegFile.file_array[3], 32'd8); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[4]  !== 32'd2) $display("FAIL sub: got %h expected %h", dut.RegFile.file_array[4], 32'd2); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[5]  !== 32'd1) $display("FAIL slt: got %h expected %h", dut.RegFile.file_array[5], 32'd1); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[6]  !== 32'd20) $display("FAIL sll: got %h expected %h", dut.RegFile.file_array[6], 32'd20); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[13] !== 32'd1) $display("FAIL slt_signed: got %h expected %h", dut.RegFile.file_array[13], 32'd1); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[14] !== 32'd1) $display("FAIL and: got %h expected %h", dut.RegFile.file_array[14], 32'd1); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[15] !== 32'd7) $display("FAIL or: got %h expected %h", dut.RegFile.file_array[15], 32'd7); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[16] !== 32'd4) $display("FAIL add_wrap: got %h expected %h", dut.RegFile.file_array[16], 32'd4); else pass_cnt++;
  endtask

  task automatic test_mult;
    hold_reset();
    put_instr(0,  i_op(9, 0, 7, -1));       // ADDIU $7,$0,-1
    put_instr(16, r_op(7, 7, 0, 0, 25));    // MULTU $7,$7
    put_instr(20, r_op(0, 0, 8, 0, 16));    // MFHI $8
    put_instr(24, r_op(0, 0, 9, 0, 18));    // MFLO $9
    release_reset();
    run(12);
    chk_cnt++; if (dut.RegFile.file_array[7] !== 32'hFFFF_FFFF) $display("FAIL addiu_neg: got %h expected %h", dut.RegFile.file_array[7], 32'hFFFF_FFFF); else pass_cnt++;
    chk_cnt++; if (dut.hi_q !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h expected %h", dut.hi_q, 32'hFFFF_FFFE); else pass_cnt++;
    chk_cnt++; if (dut.lo_q !== 32'd1) $display("FAIL multu_lo: got %h expected %h", dut.lo_q, 32'd1); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[8] !== 32'hFFFF_FFFE) $display("FAIL mfhi: got %h expected %h", dut.RegFile.file_array[8], 32'hFFFF_FFFE); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[9] !== 32'd1) $display("FAIL mflo: got %h expected %h", dut.RegFile.file_array[9], 32'd1); else pass_cnt++;
  endtask

  task automatic test_load_store;
    logic [31:0] w;
    hold_reset();
    dut.DatMem.mem_array[0] = 8'h78; dut.DatMem.mem_array[1] = 8'h56;
    dut.DatMem.mem_array[2] = 8'h34; dut.DatMem.mem_array[3] = 8'h12;
    for (int i = 8; i < 12; i++) dut.DatMem.mem_array[i] = 8'h00;
    dut.RegFile.file_array[15] = 32'd12;
    put_instr(0,  i_op(35, 0, 10, 0));      // LW $10,0($0)
    put_instr(16, i_op(43, 0, 10, 8));      // SW $10,8($0)
    put_instr(20, i_op(35, 15, 14, -12));   // LW $14,-12($15)
    release_reset();
    run(12);
    w = {dut.DatMem.mem_array[11], dut.DatMem.mem_array[10], dut.DatMem.mem_array[9], dut.DatMem.mem_array[8]};
    chk_cnt++; if (dut.RegFile.file_array[10] !== 32'h1234_5678) $display("FAIL lw: got %h expected %h", dut.RegFile.file_array[10], 32'h1234_5678); else pass_cnt++;
    chk_cnt++; if (w !== 32'h1234_5678) $display("FAIL sw: got %h expected %h", w, 32'h1234_5678); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[14] !== 32'h1234_5678) $display("FAIL lw_negoff: got %h expected %h", dut.RegFile.file_array[14], 32'h1234_5678); else pass_cnt++;
  endtask

  task automatic test_branch;
    hold_reset();
    for (int r = 16; r <= 20; r++) dut.RegFile.file_array[r] = 32'hAA;
    put_instr(0,  i_op(4, 0, 0, 2));        // BEQ $0,$0,+2 -> 12
    put_instr(4,  i_op(9, 0, 16, 1));       // flushed
    put_instr(8,  i_op(9, 0, 17, 2));       // flushed
    put_instr(12, i_op(9, 0, 18, 3));
    put_instr(16, i_op(5, 0, 0, 2));        // BNE $0,$0 not taken
    put_instr(20, i_op(9, 0, 19, 4));
    put_instr(24, i_op(9, 0, 20, 5));
    release_reset();
    run(14);
    chk_cnt++; if (dut.RegFile.file_array[16] !== 32'hAA) $display("FAIL beq_flush1: got %h expected %h", dut.RegFile.file_array[16], 32'hAA); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[17] !== 32'hAA) $display("FAIL beq_flush2: got %h expected %h", dut.RegFile.file_array[17], 32'hAA); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[18] !== 32'd3) $display("FAIL beq_target: got %h expected %h", dut.RegFile.file_array[18], 32'd3); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[19] !== 32'd4) $display("FAIL bne_fall1: got %h expected %h", dut.RegFile.file_array[19], 32'd4); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[20] !== 32'd5) $display("FAIL bne_fall2: got %h expected %h", dut.RegFile.file_array[20], 32'd5); else pass_cnt++;
  endtask

  task automatic test_jump;
    logic [31:0] tgt_word;
    tgt_word = i_op(9, 0, 22, 9);
    hold_reset();
    dut.RegFile.file_array[21] = 32'hAA;
    dut.RegFile.file_array[22] = 32'hAA;
    put_instr(0,    j_op(32'h20));          // J 0x20
    put_instr(4,    i_op(9, 0, 21, 7));     // flushed
    put_instr(32'h20, tgt_word);
    release_reset();
    run(2);
    chk_cnt++; if (dut.pc !== 32'h20) $display("FAIL j_pc: got %h expected %h", dut.pc, 32'h20); else pass_cnt++;
    chk_cnt++; if (dut.instr_IF !== tgt_word) $display("FAIL j_fetch: got %h expected %h", dut.instr_IF, tgt_word); else pass_cnt++;
    run(8);
    chk_cnt++; if (dut.RegFile.file_array[21] !== 32'hAA) $display("FAIL j_flush: got %h expected %h", dut.RegFile.file_array[21], 32'hAA); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[22] !== 32'd9) $display("FAIL j_target: got %h expected %h", dut.RegFile.file_array[22], 32'd9); else pass_cnt++;
  endtask

  task automatic test_branch_vs_jump;
    hold_reset();
    dut.RegFile.file_array[23] = 32'hAA;
    dut.RegFile.file_array[24] = 32'hAA;
    put_instr(0,    i_op(4, 0, 0, 2));      // BEQ -> 12, in EX while J is in ID
    put_instr(4,    j_op(32'h40));
    put_instr(12,   i_op(9, 0, 23, 6));
    put_instr(32'h40, i_op(9, 0, 24, 8));
    release_reset();
    run(3);
    chk_cnt++; if (dut.pc !== 32'd12) $display("FAIL br_prio_pc: got %h expected %h", dut.pc, 32'd12); else pass_cnt++;
    run(7);
    chk_cnt++; if (dut.RegFile.file_array[23] !== 32'd6) $display("FAIL br_prio_tgt: got %h expected %h", dut.RegFile.file_array[23], 32'd6); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[24] !== 32'hAA) $display("FAIL br_prio_j: got %h expected %h", dut.RegFile.file_array[24], 32'hAA); else pass_cnt++;
  endtask

  task automatic test_reset_midway;
    hold_reset();
    dut.RegFile.file_array[25] = 32'd0;
    for (int i = 16; i < 20; i++) dut.DatMem.mem_array[i] = 8'h00;
    put_instr(0,  i_op(9, 0, 25, 32'h55));  // ADDIU $25,$0,0x55
    put_instr(16, i_op(43, 0, 25, 16));     // SW $25,16($0): MEM in cycle 7
    release_reset();
    run(7);
    rst = 1'b1;
    run(1);
    chk_cnt++; if (dut.DatMem.mem_array[16] !== 8'h00) $display("FAIL rst_sw_gate: got %h expected %h", dut.DatMem.mem_array[16], 8'h00); else pass_cnt++;
    chk_cnt++; if (dut.pc !== 32'd0) $display("FAIL rst_mid_pc: got %h expected %h", dut.pc, 32'd0); else pass_cnt++;
    rst = 1'b0;
    run(10);
    chk_cnt++; if (dut.DatMem.mem_array[16] !== 8'h55) $display("FAIL rerun_sw: got %h expected %h", dut.DatMem.mem_array[16], 8'h55); else pass_cnt++;
  endtask

`ifdef PIPE_CPU_FORWARDING_EN
  task automatic test_forwarding;
    hold_reset();
    dut.RegFile.file_array[1] = 32'd5;
    dut.RegFile.file_array[2] = 32'd3;
    dut.DatMem.mem_array[0] = 8'h78; dut.DatMem.mem_array[1] = 8'h56;
    dut.DatMem.mem_array[2] = 8'h34; dut.DatMem.mem_array[3] = 8'h12;
    put_instr(0,  r_op(1, 2, 3, 0, 32));    // ADD $3,$1,$2
    put_instr(4,  r_op(3, 3, 4, 0, 32));    // ADD $4,$3,$3
    put_instr(8,  i_op(35, 0, 10, 0));      // LW $10,0($0)
    put_instr(12, r_op(10, 1, 26, 0, 32));  // ADD $26,$10,$1 (load-use)
    release_reset();
    run(5);
    chk_cnt++; if (dut.pc !== 32'd16) $display("FAIL lu_stall_pc: got %h expected %h", dut.pc, 32'd16); else pass_cnt++;
    run(8);
    chk_cnt++; if (dut.RegFile.file_array[4] !== 32'd16) $display("FAIL fwd_add: got %h expected %h", dut.RegFile.file_array[4], 32'd16); else pass_cnt++;
    chk_cnt++; if (dut.RegFile.file_array[26] !== 32'h1234_567D) $display("FAIL fwd_load: got %h expected %h", dut.RegFile.file_array[26], 32'h1234_567D); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_load_store();
    test_branch();
    test_jump();
    test_branch_vs_jump();
    test_reset_midway();
`ifdef PIPE_CPU_FORWARDING_EN
    test_forwarding();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
